// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, reset/bubble defaults
// and PC arithmetic helpers.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_BOOT      = 2'd0,
      ST_FETCH     = 2'd1,
      ST_MISS_WAIT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_STEP       = 32'd4;

   // Instructions are word aligned; redirect targets drop their low two bits.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous active-low reset, load, increment, hold.
module pc_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        inc,
   input  logic [31:0] load_pc,
   output logic [31:0] pc
);

   // Load beats increment; neither asserted means hold. Increment wraps mod 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n)
         pc <= RESET_PC;
      else if (load)
         pc <= load_pc;
      else if (inc)
         pc <= pc + PC_STEP;
   end

endmodule

// File: rtl/fetch_unit.sv
// PC generation and IF/ID capture in front of a combinational instruction ROM,
// handling decode stall, execute redirect and ROM miss.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        Branch,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] IMemData,
   input  logic        IMemMiss,
   output logic [31:0] IMemAddr,
   output logic        IMemEn,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PC,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid,
   output logic [31:0] FetchCount
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_p0;
   logic [31:0]  pc_plus4_p0;
   logic         pc_load, pc_inc;
   logic         capture, bubble;

   logic [31:0]  instr_p1, pc_p1, pc_plus4_p1;
   logic         vld_p1;
   logic [31:0]  fetch_cnt;

   assign pc_plus4_p0 = pc_p0 + PC_STEP;
   assign IMemAddr    = pc_p0;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (Clk),
      .rst_n   (Rst),
      .load    (pc_load),
      .inc     (pc_inc),
      .load_pc (align_word(BranchTarget)),
      .pc      (pc_p0)
   );

   always_ff @(posedge Clk) begin
      if (!Rst)
         state_q <= ST_BOOT;
      else
         state_q <= state_d;
   end

   // FETCH and MISS_WAIT share one priority chain: Branch > Stall > Miss > capture.
   always_comb begin
      state_d = state_q;
      pc_load = 1'b0;
      pc_inc  = 1'b0;
      capture = 1'b0;
      bubble  = 1'b0;
      IMemEn  = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH, ST_MISS_WAIT: begin
            IMemEn = !(Stall && !Branch);
            if (Branch) begin
               pc_load = 1'b1;
               bubble  = 1'b1;
               state_d = ST_FETCH;
            end else if (!Stall) begin
               if (IMemMiss) begin
                  bubble  = 1'b1;
                  state_d = ST_MISS_WAIT;
               end else begin
                  capture = 1'b1;
                  pc_inc  = 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
      if (!Rst)
         IMemEn = 1'b0;
   end

   // ---- IF/ID boundary (p0 -> p1) ----
   // A bubble only rewrites Instr/Valid; the PC fields keep their last values.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         instr_p1    <= NOP_INSTR;
         pc_p1       <= 32'd0;
         pc_plus4_p1 <= 32'd0;
         vld_p1      <= 1'b0;
         fetch_cnt   <= 32'd0;
      end else if (capture) begin
         instr_p1    <= IMemData;
         pc_p1       <= pc_p0;
         pc_plus4_p1 <= pc_plus4_p0;
         vld_p1      <= 1'b1;
         fetch_cnt   <= fetch_cnt + 32'd1;
      end else if (bubble) begin
         instr_p1    <= NOP_INSTR;
         vld_p1      <= 1'b0;
      end
   end

   assign IFID_Instr   = instr_p1;
   assign IFID_PC      = pc_p1;
   assign IFID_PCPlus4 = pc_plus4_p1;
   assign IFID_Valid   = vld_p1;
   assign FetchCount   = fetch_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a behavioural model of the fetch rules.
module tb_fetch_unit;

   logic        Clk = 1'b0;
   logic        Rst, Stall, Branch, IMemMiss;
   logic [31:0] BranchTarget, IMemData, IMemAddr;
   logic        IMemEn, IFID_Valid;
   logic [31:0] IFID_Instr, IFID_PC, IFID_PCPlus4, FetchCount;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   // ROM contents: an address-dependent pattern so each word is distinguishable.
   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
   endfunction

   assign IMemData = rom(IMemAddr);

   fetch_unit dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .Stall        (Stall),
      .Branch       (Branch),
      .BranchTarget (BranchTarget),
      .IMemData     (IMemData),
      .IMemMiss     (IMemMiss),
      .IMemAddr     (IMemAddr),
      .IMemEn       (IMemEn),
      .IFID_Instr   (IFID_Instr),
      .IFID_PC      (IFID_PC),
      .IFID_PCPlus4 (IFID_PCPlus4),
      .IFID_Valid   (IFID_Valid),
      .FetchCount   (FetchCount)
   );

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset;
      Rst = 1'b0; Stall = 1'b0; Branch = 1'b0; IMemMiss = 1'b0; BranchTarget = 32'd0;
      tick; tick;
      checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", IFID_Valid); end
      checks++; if (IFID_Instr !== 32'd0) begin errors++; $display("FAIL rst_instr: got %h want 0", IFID_Instr); end
      checks++; if (IFID_PC !== 32'd0 || IFID_PCPlus4 !== 32'd0) begin errors++; $display("FAIL rst_pcs: got %h/%h want 0/0", IFID_PC, IFID_PCPlus4); end
      checks++; if (FetchCount !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", FetchCount); end
      checks++; if (IMemAddr !== 32'd0 || IMemEn !== 1'b0) begin errors++; $display("FAIL rst_mem: got addr %h en %b want 0 0", IMemAddr, IMemEn); end
      Rst = 1'b1;
      #1;
      checks++; if (IMemEn !== 1'b0) begin errors++; $display("FAIL boot_en: got %b want 0", IMemEn); end
      tick;
      checks++; if (IFID_Valid !== 1'b0 || IMemAddr !== 32'd0) begin errors++; $display("FAIL boot_hold: got valid %b addr %h want 0 0", IFID_Valid, IMemAddr); end
      checks++; if (IMemEn !== 1'b1) begin errors++; $display("FAIL fetch_en: got %b want 1", IMemEn); end
   endtask

   task automatic test_run;
      logic [31:0] a;
      for (int i = 0; i < 3; i++) begin
         tick;
         a = 32'(4 * i);
         checks++; if (IFID_PC !== a || IFID_PCPlus4 !== a + 32'd4) begin errors++; $display("FAIL run_pc%0d: got %h/%h want %h/%h", i, IFID_PC, IFID_PCPlus4, a, a + 32'd4); end
         checks++; if (IFID_Instr !== rom(a) || IFID_Valid !== 1'b1) begin errors++; $display("FAIL run_instr%0d: got %h v%b want %h v1", i, IFID_Instr, IFID_Valid, rom(a)); end
         checks++; if (FetchCount !== 32'(i + 1)) begin errors++; $display("FAIL run_count%0d: got %0d want %0d", i, FetchCount, i + 1); end
      end
   endtask

   task automatic test_stall;
      Stall = 1'b1;
      #1;
      checks++; if (IMemEn !== 1'b0) begin errors++; $display("FAIL stall_en: got %b want 0", IMemEn); end
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (IFID_PC !== 32'd8 || IMemAddr !== 32'd12 || FetchCount !== 32'd3) begin errors++; $display("FAIL stall_hold%0d: got pc %h addr %h cnt %0d want 8 c 3", i, IFID_PC, IMemAddr, FetchCount); end
      end
      Stall = 1'b0;
      tick;
      checks++; if (IFID_PC !== 32'd12 || IFID_Valid !== 1'b1 || FetchCount !== 32'd4) begin errors++; $display("FAIL stall_release: got pc %h v%b cnt %0d want c 1 4", IFID_PC, IFID_Valid, FetchCount); end
   endtask

   task automatic test_branch;
      Branch = 1'b1; BranchTarget = 32'h0000_0043;
      tick;
      checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 32'd0 || IMemAddr !== 32'h40) begin errors++; $display("FAIL br_bubble: got v%b instr %h addr %h want 0 0 40", IFID_Valid, IFID_Instr, IMemAddr); end
      Branch = 1'b0;
      tick;
      checks++; if (IFID_PC !== 32'h40 || IFID_PCPlus4 !== 32'h44 || IFID_Valid !== 1'b1) begin errors++; $display("FAIL br_target: got %h/%h v%b want 40/44 v1", IFID_PC, IFID_PCPlus4, IFID_Valid); end
      checks++; if (IFID_Instr !== rom(32'h40) || FetchCount !== 32'd5) begin errors++; $display("FAIL br_instr: got %h cnt %0d want %h 5", IFID_Instr, FetchCount, rom(32'h40)); end
   endtask

   task automatic test_branch_stall;
      Branch = 1'b1; Stall = 1'b1; BranchTarget = 32'h0000_0080;
      #1;
      checks++; if (IMemEn !== 1'b1) begin errors++; $display("FAIL brst_en: got %b want 1", IMemEn); end
      tick;
      checks++; if (IMemAddr !== 32'h80 || IFID_Valid !== 1'b0) begin errors++; $display("FAIL brst_redirect: got addr %h v%b want 80 0", IMemAddr, IFID_Valid); end
      Branch = 1'b0; Stall = 1'b0;
      tick;
      checks++; if (IFID_PC !== 32'h80 || IFID_Valid !== 1'b1 || FetchCount !== 32'd6) begin errors++; $display("FAIL brst_target: got %h v%b cnt %0d want 80 1 6", IFID_PC, IFID_Valid, FetchCount); end
   endtask

   task automatic test_miss;
      Branch = 1'b1; BranchTarget = 32'd20;
      tick;
      Branch = 1'b0; IMemMiss = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick;
         checks++; if (IFID_Valid !== 1'b0 || IMemAddr !== 32'd20 || FetchCount !== 32'd6) begin errors++; $display("FAIL miss_hold%0d: got v%b addr %h cnt %0d want 0 14 6", i, IFID_Valid, IMemAddr, FetchCount); end
      end
      checks++; if (IMemEn !== 1'b1) begin errors++; $display("FAIL miss_en: got %b want 1", IMemEn); end
      IMemMiss = 1'b0;
      tick;
      checks++; if (IFID_PC !== 32'd20 || IFID_Valid !== 1'b1 || IFID_Instr !== rom(32'd20)) begin errors++; $display("FAIL miss_clear: got %h v%b %h want 14 1 %h", IFID_PC, IFID_Valid, IFID_Instr, rom(32'd20)); end
      IMemMiss = 1'b1;
      tick;
      Branch = 1'b1; BranchTarget = 32'h100;
      tick;
      checks++; if (IFID_Valid !== 1'b0 || IMemAddr !== 32'h100) begin errors++; $display("FAIL miss_branch: got v%b addr %h want 0 100", IFID_Valid, IMemAddr); end
      Branch = 1'b0; IMemMiss = 1'b0;
      tick;
      checks++; if (IFID_PC !== 32'h100 || IFID_Valid !== 1'b1 || FetchCount !== 32'd8) begin errors++; $display("FAIL miss_resume: got %h v%b cnt %0d want 100 1 8", IFID_PC, IFID_Valid, FetchCount); end
   endtask

   task automatic test_wrap_reset;
      Branch = 1'b1; BranchTarget = 32'hFFFF_FFFE;
      tick;
      checks++; if (IMemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h want fffffffc", IMemAddr); end
      Branch = 1'b0;
      tick;
      checks++; if (IFID_PC !== 32'hFFFF_FFFC || IFID_PCPlus4 !== 32'd0 || IMemAddr !== 32'd0) begin errors++; $display("FAIL wrap_pc: got %h/%h addr %h want fffffffc/0 0", IFID_PC, IFID_PCPlus4, IMemAddr); end
      IMemMiss = 1'b1;
      tick;
      Rst = 1'b0; Stall = 1'b1;
      #1;
      checks++; if (IMemEn !== 1'b0) begin errors++; $display("FAIL rstmiss_en: got %b want 0", IMemEn); end
      tick;
      checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== 32'd0 || IFID_PC !== 32'd0 || IFID_PCPlus4 !== 32'd0) begin errors++; $display("FAIL rstmiss_ifid: got v%b %h %h %h want all 0", IFID_Valid, IFID_Instr, IFID_PC, IFID_PCPlus4); end
      checks++; if (FetchCount !== 32'd0 || IMemAddr !== 32'd0) begin errors++; $display("FAIL rstmiss_state: got cnt %0d addr %h want 0 0", FetchCount, IMemAddr); end
      Rst = 1'b1; Stall = 1'b0; IMemMiss = 1'b0;
   endtask

   task automatic test_random;
      logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_cnt, tgt;
      logic        m_boot, m_vld, exp_en;
      bit          r, br, st, ms;
      m_pc = 32'd0; m_instr = 32'd0; m_ifpc = 32'd0; m_ifpc4 = 32'd0; m_cnt = 32'd0;
      m_boot = 1'b1; m_vld = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         r   = (n == 0) || ($urandom_range(99) < 2);
         br  = $urandom_range(99) < 12;
         st  = $urandom_range(99) < 20;
         ms  = $urandom_range(99) < 20;
         tgt = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         Rst = !r; Branch = br; Stall = st; IMemMiss = ms; BranchTarget = tgt;
         #1;
         if (n > 0) begin
            exp_en = !r && !m_boot && !(st && !br);
            checks++; if (IMemEn !== exp_en || IMemAddr !== m_pc) begin errors++; $display("FAIL rnd_mem@%0d: got en %b addr %h want %b %h", n, IMemEn, IMemAddr, exp_en, m_pc); end
         end
         if (r) begin
            m_pc = 32'd0; m_boot = 1'b1; m_vld = 1'b0; m_instr = 32'd0;
            m_ifpc = 32'd0; m_ifpc4 = 32'd0; m_cnt = 32'd0;
         end else if (m_boot) begin
            m_boot = 1'b0;
         end else if (br) begin
            m_pc = tgt & 32'hFFFF_FFFC; m_vld = 1'b0; m_instr = 32'd0;
         end else if (!st) begin
            if (ms) begin
               m_vld = 1'b0; m_instr = 32'd0;
            end else begin
               m_vld = 1'b1; m_instr = rom(m_pc); m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
               m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
            end
         end
         tick;
         checks++; if (IFID_Valid !== m_vld || IFID_Instr !== m_instr || FetchCount !== m_cnt) begin errors++; $display("FAIL rnd_ifid@%0d: got v%b %h cnt %0d want v%b %h %0d", n, IFID_Valid, IFID_Instr, FetchCount, m_vld, m_instr, m_cnt); end
         if (m_vld) begin
            checks++; if (IFID_PC !== m_ifpc || IFID_PCPlus4 !== m_ifpc4) begin errors++; $display("FAIL rnd_pc@%0d: got %h/%h want %h/%h", n, IFID_PC, IFID_PCPlus4, m_ifpc, m_ifpc4); end
         end
      end
      Rst = 1'b1; Branch = 1'b0; Stall = 1'b0; IMemMiss = 1'b0;
   endtask

   initial begin
      test_reset;
      test_run;
      test_stall;
      test_branch;
      test_branch_stall;
      test_miss;
      test_wrap_reset;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC-generation and IF/ID capture stage that sits directly upstream of the instruction ROM.
- Drives the ROM address and enable, and absorbs the ROM miss signal.
- Applies decode-stage stall and execute-stage branch redirect.
- Registers the fetched instruction, its PC and PC+4 into the IF/ID pipeline register consumed by decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  reset; synchronous, active-low (Rst=0 resets on the rising Clk).
- Stall  input  1  decode hazard; hold PC and IF/ID.
- Branch  input  1  taken branch/jump redirect from execute.
- BranchTarget  input  32  redirect address; bits [1:0] ignored (forced 0).
- IMemData  input  32  instruction word from ROM (combinational read).
- IMemMiss  input  1  ROM miss; data not yet valid.
- IMemAddr  output  32  ROM address; always equals the PC register.
- IMemEn  output  1  ROM output enable.
- IFID_Instr  output  32  registered instruction.
- IFID_PC  output  32  registered PC of that instruction.
- IFID_PCPlus4  output  32  registered PC+4.
- IFID_Valid  output  1  IF/ID holds a real instruction (0 = bubble).
- FetchCount  output  32  number of instructions captured into IF/ID.

Behaviour:
- Reset (Rst=0 at edge):
  - PC=RESET_PC, state=BOOT.
  - IFID_Instr=NOP_INSTR, IFID_PC=0, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0.
  - IMemEn=0 while in BOOT.
- FSM states BOOT, FETCH, MISS_WAIT. All registered; all outputs except IMemEn are register outputs.
- BOOT: lasts exactly one cycle after reset release. IF/ID holds bubble, PC held. Next state FETCH.
- FETCH, evaluated in priority order Branch > Stall > Miss > normal:
  - Branch=1: PC<=BranchTarget&~3; IF/ID<=bubble (Valid=0, Instr=NOP_INSTR); stay FETCH. The Stall input is ignored that cycle.
  - Stall=1: PC and all IF/ID registers hold; IMemEn=0 (ROM holds its output).
  - IMemMiss=1: PC holds; IF/ID<=bubble; go MISS_WAIT.
  - Otherwise: IF/ID<={IMemData, PC, PC+4, Valid=1}; PC<=PC+4; FetchCount++.
- MISS_WAIT:
  - IMemEn=1, IMemAddr=PC.
  - Branch=1: redirect as in FETCH; go FETCH (pending miss abandoned).
  - Stall=1: hold everything; stay.
  - IMemMiss=1: IF/ID stays bubble; stay.
  - IMemMiss=0: capture as normal FETCH; go FETCH.
- IMemEn = 1 in FETCH/MISS_WAIT unless (Stall=1 and Branch=0); 0 in BOOT and during reset.
- Latency:
  - ROM read is combinational, so an instruction at PC appears on IFID_* one edge after PC is presented.
  - A redirect costs one bubble cycle. The target instruction is valid two edges after Branch is sampled.
- Arithmetic:
  - PC+4 and FetchCount wrap modulo 2^32.
  - PC=32'hFFFF_FFFC advances to 0 with no flag.
- Reset asserted mid-miss or mid-stall overrides all inputs: full reset values next edge.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding (2-bit).
  - NOP_INSTR, RESET_PC defaults.
  - PC_STEP=4.
- Optional sub-module pc_reg: PC register with reset/hold/load/increment. Next-PC priority logic stays in fetch_unit.

Test Plan:
- Reset then run: Rst=0 two cycles, release.
  - IFID_Valid=0 for BOOT cycle, then IFID_PC sequence 0,4,8,12.
  - IFID_Instr=mem[0..3]; FetchCount=4 after four captures.
- Stall: assert Stall for 3 cycles while IFID_PC=8.
  - IFID_PC stays 8, IMemAddr stays 12, IMemEn=0.
  - After release, next IFID_PC=12.
- Branch: Branch=1, BranchTarget=32'h0000_0043 while PC=16.
  - Next edge IFID_Valid=0, IMemAddr=0x40.
  - Following edge IFID_PC=0x40, IFID_PCPlus4=0x44, Valid=1.
- Branch and Stall together, Branch=1, Stall=1, target 0x80: redirect wins; PC=0x80, IF/ID bubble.
- Miss: IMemMiss=1 for 2 cycles at PC=20.
  - IFID_Valid=0 for those cycles, PC held at 20.
  - On miss clear, IFID_PC=20, Valid=1.
  - Branch during MISS_WAIT returns to FETCH at target.
- Wrap and reset: run from PC=0xFFFF_FFFC; IFID_PCPlus4=0, next PC=0. Then assert Rst=0 during a miss: all outputs reach reset values next edge.
